cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Converts one 256-bit cache-line transaction from the cache arbiter's physical-memory port into a 4-beat, 64-bit burst on the physical memory bus, and reassembles read bursts into a full line. It sits directly downstream of the cache arbiter: the arbiter's pmem_* outputs drive the line side, and main memory drives the burst side. One transaction is in flight at a time.

## Interface
- LINE_W, 256, cache-line width in bits.
- BURST_W, 64, memory bus beat width; BEATS = LINE_W/BURST_W = 4. LINE_W must be an exact multiple of BURST_W.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- line_i  in  LINE_W  write line from arbiter (pmem_wdata).
- line_o  out  LINE_W  read line to arbiter (pmem_rdata).
- address_i  in  32  line address from arbiter.
- read_i  in  1  line read request.
- write_i  in  1  line write request.
- resp_o  out  1  one-cycle completion pulse to arbiter (pmem_resp).
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  32  burst address to memory, line-aligned.
- read_o  out  1  burst read request.
- write_o  out  1  burst write request.
- resp_i  in  1  memory beat strobe; one beat transferred per cycle it is high.

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: state, 2-bit beat counter, LINE_W buffer, 32-bit address.
- IDLE: read_i high -> latch {address_i[31:5],5'b0}, beat=0, go READ. Else write_i high -> latch aligned address, buffer<=line_i, beat=0, go WRITE. read_i has priority when both high. resp_i ignored.
- READ: read_o=1. Each cycle resp_i=1: buffer[BURST_W*beat +: BURST_W]<=burst_i, beat++. Beat 3 accepted -> DONE. Gaps (resp_i=0) allowed anywhere; state and beat hold.
- WRITE: write_o=1, burst_o=buffer[BURST_W*beat +: BURST_W]. Each cycle resp_i=1 consumes current beat, beat++. Beat 3 consumed -> DONE.
- DONE: resp_o=1 for exactly one cycle, then IDLE. resp_i ignored.
- address_o = latched address in all states; read_o/write_o/resp_o decoded from state (no combinational path from inputs).
- line_o = buffer continuously; meaningful only in the resp_o cycle of a read, and held stable afterwards until the next transaction modifies the buffer.
- Beat order is fixed ascending: beat 0 = bits [63:0], beat 3 = bits [255:192]. Beat counter wraps 3->0 on the final beat.
- Upstream contract: arbiter deasserts read_i/write_i in the cycle after resp_o. If still high in the IDLE cycle after DONE, it is treated as a new transaction.
- Requests changing while in READ/WRITE/DONE are ignored; latched address/data are used.

## Timing
- Reset values (cycle after rst sampled high): state IDLE, beat 0, buffer 0, address 0; resp_o=0, read_o=0, write_o=0, address_o=0, line_o=0, burst_o=0.
- Reset mid-transaction aborts immediately; no resp_o; memory burst abandoned.
- Request sampled on edge E0 -> read_o/write_o high from cycle after E0.
- Best-case latency (resp_i high on 4 consecutive cycles): request high in cycle 0, read_o/write_o in cycles 1-4, resp_o in cycle 5. Each resp_i gap adds one cycle.
- read_o/write_o drop in the DONE cycle.
- Back-to-back: earliest new request is accepted in the IDLE cycle following DONE; minimum 6 cycles per transaction.

## Test plan
- Read: read_i=1, address_i=0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 consecutively -> address_o=0x0000_1220, read_o cycles 1-4, resp_o cycle 5 only, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write: write_i=1, address_i=0x8000_0040, line_i={64'hD,64'hC,64'hB,64'hA}; resp_i high 4 cycles -> burst_o A,B,C,D in order, write_o cycles 1-4, resp_o cycle 5.
- Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> beats stored only on high cycles, resp_o exactly one cycle after 4th beat, read_o held throughout.
- Priority/ignore: read_i and write_i both high in IDLE -> read performed, write_o never high; address_i changed mid-burst -> address_o unchanged; resp_i pulses in IDLE -> no state change.
- Reset mid-read after 2 beats -> next cycle all outputs reset values, no resp_o; following read completes normally with correct line.
- Back-to-back: read_i held after resp_o for one extra cycle -> second read starts from the IDLE cycle, two resp_o pulses, 6 cycles apart with zero-wait memory.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor_if
// Brief    : Line-side and burst-side signal bundle for cacheline_adaptor.
// Revision : 1.0
// ============================================================================
interface cacheline_adaptor_if #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  // Environment side: arbiter plus main memory.
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : cacheline_adaptor
// Brief    : Splits a cache-line transaction into a fixed-order memory burst
//            and reassembles read bursts into a full line.
// Revision : 1.0
// ============================================================================
module cacheline_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  cacheline_adaptor_if.slave bus
);
  localparam int BEATS  = LINE_W / BURST_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [31:0] ALIGN_MASK = ~(32'(LINE_W / 8) - 32'd1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [BEAT_W-1:0] r_beat;
  logic [LINE_W-1:0] r_buffer;
  logic [31:0]       r_address;

  logic              w_last;
  logic [31:0]       w_aligned;
  logic [BEAT_W-1:0] w_beat_next;

  assign w_last      = (r_beat == BEAT_W'(BEATS - 1));
  assign w_aligned   = bus.address_i & ALIGN_MASK;
  assign w_beat_next = w_last ? '0 : r_beat + BEAT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_beat    <= '0;
      r_buffer  <= '0;
      r_address <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Read wins when the arbiter raises both requests together.
          if (bus.read_i) begin
            r_address <= w_aligned;
            r_beat    <= '0;
            r_state   <= READ;
          end else if (bus.write_i) begin
            r_address <= w_aligned;
            r_buffer  <= bus.line_i;
            r_beat    <= '0;
            r_state   <= WRITE;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            r_buffer[int'(r_beat) * BURST_W +: BURST_W] <= bus.burst_i;
            r_beat <= w_beat_next;
            if (w_last) r_state <= DONE;
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            r_beat <= w_beat_next;
            if (w_last) r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // All outputs come from registers only, so the memory strobe never
  // reaches the arbiter combinationally.
  assign bus.read_o    = (r_state == READ);
  assign bus.write_o   = (r_state == WRITE);
  assign bus.resp_o    = (r_state == DONE);
  assign bus.address_o = r_address;
  assign bus.line_o    = r_buffer;
  assign bus.burst_o   = r_buffer[int'(r_beat) * BURST_W +: BURST_W];

endmodule
`default_nettype wire

// File: tb/tb_cacheline_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_adaptor
// Brief    : Directed scoreboard bench for cacheline_adaptor.
// Revision : 1.0
// ============================================================================
module tb_cacheline_adaptor;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  localparam logic [LINE_W-1:0] L_RD = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [LINE_W-1:0] L_WR = {64'hD, 64'hC, 64'hB, 64'hA};
  localparam logic [LINE_W-1:0] L_G  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                        64'hA5A5_5A5A_F00D_CAFE, 64'h1357_9BDF_2468_ACE0};
  localparam logic [LINE_W-1:0] L_W2 = {64'h5555_0000_5555_0000, 64'h0000_AAAA_0000_AAAA,
                                        64'hDEAD_BEEF_0000_0001, 64'h8000_0000_0000_0000};
  localparam logic [LINE_W-1:0] L_P  = {64'hCCCC_0000_1111_2222, 64'h3333_4444_5555_6666,
                                        64'h7777_8888_9999_AAAA, 64'hBBBB_CCCC_DDDD_EEEE};
  localparam logic [LINE_W-1:0] L_R  = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                                        64'h0000_FFFF_0000_FFFF, 64'hFFFF_0000_FFFF_0000};
  localparam logic [LINE_W-1:0] L_A  = {64'h1, 64'h2, 64'h3, 64'h4};
  localparam logic [LINE_W-1:0] L_B  = {64'h9, 64'h8, 64'h7, 64'h6};
  localparam logic [BURST_W-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W)) bus();

  cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic              is_read;
    logic [31:0]       addr;
    logic [LINE_W-1:0] line;
  } exp_t;

  exp_t               exp_q[$];
  logic [BURST_W-1:0] wbeat_q[$];
  int                 resp_cyc_q[$];
  exp_t               mon_e;
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation for every completion pulse and every
  // accepted write beat.
  always @(negedge clk) begin
    if (bus.resp_o === 1'b1) begin
      resp_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", bus.resp_o, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_addr", bus.address_o, mon_e.addr);
        if (mon_e.is_read) chk("read_line", bus.line_o, mon_e.line);
      end
    end
    if (bus.write_o === 1'b1 && bus.resp_i === 1'b1) begin
      if (wbeat_q.size() == 0) chk("unexpected_wbeat", bus.write_o, 0);
      else chk("write_beat", bus.burst_o, wbeat_q.pop_front());
    end
  end

  task automatic do_read(input logic [31:0] a, input logic [LINE_W-1:0] line,
                         input logic [15:0] pat, input int pat_len,
                         input logic also_write, input logic chain,
                         input logic [31:0] next_a);
    logic [31:0] al;
    exp_t        e;
    int          k;
    int          p;
    logic        b;
    al = {a[31:5], 5'b0};
    e.is_read = 1'b1; e.addr = al; e.line = line;
    exp_q.push_back(e);
    bus.read_i = 1'b1; bus.write_i = also_write; bus.address_i = a; bus.line_i = ~line;
    tick();
    bus.read_i = 1'b0; bus.write_i = 1'b0; bus.address_i = ~a;
    k = 0; p = 0;
    while (k < BEATS) begin
      chk("read_o_high", bus.read_o, 1);
      chk("write_o_low", bus.write_o, 0);
      chk("addr_held", bus.address_o, al);
      b = (p < pat_len) ? pat[p] : 1'b1;
      p++;
      bus.resp_i  = b;
      bus.burst_i = b ? line[k*BURST_W +: BURST_W] : JUNK;
      tick();
      if (b) k++;
    end
    bus.resp_i = 1'b0; bus.burst_i = JUNK;
    if (chain) begin
      bus.read_i = 1'b1; bus.address_i = next_a;
    end
    chk("done_resp_o", bus.resp_o, 1);
    chk("done_read_o", bus.read_o, 0);
    tick();
    chk("idle_resp_o", bus.resp_o, 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [LINE_W-1:0] line,
                          input logic [15:0] pat, input int pat_len);
    logic [31:0] al;
    exp_t        e;
    int          k;
    int          p;
    logic        b;
    al = {a[31:5], 5'b0};
    e.is_read = 1'b0; e.addr = al; e.line = '0;
    exp_q.push_back(e);
    for (int i = 0; i < BEATS; i++) wbeat_q.push_back(line[i*BURST_W +: BURST_W]);
    bus.write_i = 1'b1; bus.address_i = a; bus.line_i = line;
    tick();
    bus.write_i = 1'b0; bus.address_i = ~a; bus.line_i = ~line;
    k = 0; p = 0;
    while (k < BEATS) begin
      chk("write_o_high", bus.write_o, 1);
      chk("read_o_low", bus.read_o, 0);
      chk("addr_held", bus.address_o, al);
      b = (p < pat_len) ? pat[p] : 1'b1;
      p++;
      bus.resp_i  = b;
      bus.burst_i = JUNK;
      tick();
      if (b) k++;
    end
    bus.resp_i = 1'b0;
    chk("done_resp_o", bus.resp_o, 1);
    chk("done_write_o", bus.write_o, 0);
    tick();
    chk("idle_resp_o", bus.resp_o, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_resp_o"}, bus.resp_o, 0);
    chk({tag, "_read_o"}, bus.read_o, 0);
    chk({tag, "_write_o"}, bus.write_o, 0);
    chk({tag, "_address_o"}, bus.address_o, 0);
    chk({tag, "_line_o"}, bus.line_o, 0);
    chk({tag, "_burst_o"}, bus.burst_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.line_i = '0; bus.address_i = '0; bus.read_i = 1'b0; bus.write_i = 1'b0;
    bus.burst_i = '0; bus.resp_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // Memory strobes while idle must not move the state machine.
    bus.resp_i = 1'b1; bus.burst_i = JUNK;
    tick(); tick();
    chk("idle_strobe_read_o", bus.read_o, 0);
    chk("idle_strobe_write_o", bus.write_o, 0);
    bus.resp_i = 1'b0;
    tick();
    chk("idle_strobe_line_o", bus.line_o, 0);

    do_read(32'h0000_1234, L_RD, 16'h000F, 4, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("line_o_held", bus.line_o, L_RD);
    chk("addr_o_held", bus.address_o, 32'h0000_1220);

    do_write(32'h8000_0040, L_WR, 16'h000F, 4);
    do_read(32'h0000_0ABC, L_G, 16'h0059, 7, 1'b0, 1'b0, 32'h0);
    do_write(32'h1234_5678, L_W2, 16'h0035, 6);
    do_read(32'hFFFF_FFE7, L_P, 16'h000F, 4, 1'b1, 1'b0, 32'h0);

    // Abort a read after two beats.
    bus.read_i = 1'b1; bus.address_i = 32'h0000_5555;
    tick();
    bus.read_i = 1'b0;
    bus.resp_i = 1'b1; bus.burst_i = {16{4'h7}};
    tick();
    bus.burst_i = {16{4'h8}};
    tick();
    bus.resp_i = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("abort");
    tick(); tick();
    chk("abort_no_resp", bus.resp_o, 0);
    chk("abort_idle_read_o", bus.read_o, 0);
    do_read(32'h0000_5555, L_R, 16'h000F, 4, 1'b0, 1'b0, 32'h0);

    resp_cyc_q.delete();
    do_read(32'h0000_2000, L_A, 16'h000F, 4, 1'b0, 1'b1, 32'h0000_3000);
    do_read(32'h0000_3000, L_B, 16'h000F, 4, 1'b0, 1'b0, 32'h0);
    chk("b2b_resp_count", resp_cyc_q.size(), 2);
    if (resp_cyc_q.size() >= 2) chk("b2b_gap", resp_cyc_q[1] - resp_cyc_q[0], 6);

    tick(); tick();
    chk("final_resp_o", bus.resp_o, 0);
    chk("scoreboard_drained", exp_q.size() + wbeat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire
